namuru_accumulator: RTL
=======================

Name: namuru_accumulator

Overview:
- Correlator back end for one tracking channel. It sits directly downstream of the C/A code generator and the carrier mixer.
- Multiplies carrier-wiped I/Q baseband samples by the early, prompt and late chips, and integrates the six products over one C/A code period.
- On each dump_enable it latches the six sums plus a sample count into holding registers for software readout, and restarts integration.

Parameters:
- SAMPLE_W, 3, signed width of i_baseband and q_baseband.
- ACC_W, 16, width of each accumulator and holding register (signed).
- CNT_W, 16, width of the per-dump sample counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- sample_enable  in  1  one-cycle strobe: baseband sample valid
- i_baseband  in  SAMPLE_W  signed in-phase sample after carrier mixing
- q_baseband  in  SAMPLE_W  signed quadrature sample after carrier mixing
- early  in  1  early chip from code generator
- prompt  in  1  prompt chip
- late  in  1  late chip
- dump_enable  in  1  one-cycle pulse at C/A period boundary
- accum_read  in  1  one-cycle pulse: software has read the holding registers
- i_early, q_early, i_prompt, q_prompt, i_late, q_late  out  ACC_W each  latched correlation sums (signed)
- sample_count  out  CNT_W  number of sample_enable strobes in the latched interval
- accum_valid  out  1  new dump latched and not yet read
- accum_overwrite  out  1  sticky: a dump was latched while accum_valid was still set

Behaviour:
- Reset: clk and rstn are fixed as stated above; reset is synchronous and active-low. rstn=0 at a clk edge clears all accumulators, the counter, all holding registers, accum_valid and accum_overwrite on that edge. A reset mid-interval discards the partial sums.
- Chip mapping: chip=1 gives +sample; chip=0 gives -sample (two's-complement negate, sign-extended to ACC_W).
- Running accumulation: on a cycle with sample_enable=1 and dump_enable=0, each accumulator adds its product and the counter increments.
- Dump cycle (dump_enable=1):
  - Holding registers take the running accumulator and counter values as they stood before this cycle. This cycle's sample is excluded.
  - Running accumulators restart at this cycle's product if sample_enable=1, otherwise at 0.
  - The counter restarts at 1 if sample_enable=1, otherwise at 0.
- Latency: a dump_enable at cycle N makes the holding registers, accum_valid and accum_overwrite visible at cycle N+1.
- accum_valid: set on a dump; cleared on accum_read. If both occur in the same cycle, accum_valid is 1 (the dump wins).
- accum_overwrite: set on a dump when accum_valid=1 and accum_read=0 in that cycle. Cleared only by accum_read, or by a dump and read in the same cycle.
- Arithmetic: without the optional feature, accumulators wrap modulo 2^ACC_W. The counter saturates at 2^CNT_W-1 and does not wrap.
- Holding registers are stable between dumps; accum_read does not alter them.

Optional Feature:
- Macro: NAMURU_ACCUM_SAT_EN.
- When defined: each accumulator add saturates at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)). Saturation is sticky within an interval until the next dump restart.
- When undefined: plain wrap-around addition, with no extra logic.

Decomposition:
- Shared package namuru_pkg holds:
  - default widths SAMPLE_W, ACC_W, CNT_W;
  - a chip-sign function (chip, sample) returning a sign-extended ACC_W product;
  - saturating-add function used under NAMURU_ACCUM_SAT_EN.
- One natural sub-module, namuru_accum_ch: a single signed accumulator with sample/dump/restart logic and holding register. It is instantiated six times (I/Q × E/P/L).
- Counter, valid and overwrite logic live in the top.

Test Plan:
- Constant correlation: i=+3, q=-1, early=prompt=late=1, 2046 samples, then dump.
  - Expect i_*=6138, q_*=-2046, sample_count=2046, accum_valid=1 one cycle after dump.
- Chip sign: alternate prompt 1/0 each sample with i=+2, 10 samples.
  - Expect i_prompt=0; with early held 0, i_early=-20.
- Dump-cycle boundary: sample_enable and dump_enable in the same cycle with i=+1, chips=1.
  - Expect the holding register to exclude that sample.
  - The next dump interval with no further samples reports sample_count=1 and i_*=1.
- Handshake: dump twice without accum_read.
  - Expect accum_overwrite=1 after the second dump.
  - A subsequent accum_read clears both flags.
  - A simultaneous dump and read leaves accum_valid=1 and accum_overwrite=0.
- Wrap/saturation: i=+3, chips=1, 11000 samples (ACC_W=16).
  - Expect wrapped value 33000-65536=-32536 without the macro.
  - Expect 32767 with NAMURU_ACCUM_SAT_EN.
- Reset mid-interval: 500 samples, rstn=0 one cycle, then 10 samples of i=+1 and dump.
  - Expect all outputs 0 during reset, then i_*=10 and sample_count=10.

Source files
------------

// File: rtl/namuru_pkg.sv
// Shared widths and arithmetic helpers for the namuru correlator back end.
// The saturating add is only used when NAMURU_ACCUM_SAT_EN is defined.
package namuru_pkg;

  localparam int SAMPLE_W = 3;
  localparam int ACC_W    = 16;
  localparam int CNT_W    = 16;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // The sample is sign-extended before negation so that the most negative
  // sample value negates without overflow.
  function automatic logic signed [ACC_W-1:0] chip_product(
    input logic                       chip,
    input logic signed [SAMPLE_W-1:0] sample
  );
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    return chip ? ext : -ext;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/namuru_accum_ch.sv
// One signed correlation accumulator with its dump holding register.
// Defining NAMURU_ACCUM_SAT_EN makes the running sum saturate (sticky until the next dump).
module namuru_accum_ch #(
  parameter int ACC_W = namuru_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sample_enable,
  input  logic                    dump_enable,
  input  logic signed [ACC_W-1:0] product_i,
  output logic signed [ACC_W-1:0] hold_o
);
  import namuru_pkg::*;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] hold_q, hold_d;

`ifdef NAMURU_ACCUM_SAT_EN
  logic sat_q, sat_d;
  logic signed [ACC_W-1:0] sum_sat;

  always_comb begin
    sum_sat = sat_add(acc_q, product_i);
    acc_d   = acc_q;
    hold_d  = hold_q;
    sat_d   = sat_q;
    if (dump_enable) begin
      hold_d = acc_q;
      acc_d  = sample_enable ? product_i : '0;
      sat_d  = 1'b0;
    end else if (sample_enable && !sat_q) begin
      acc_d = sum_sat;
      // Once clipped, the sum stays pinned at the rail for the rest of the interval.
      sat_d = (sum_sat != ACC_W'(acc_q + product_i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end
`else
  always_comb begin
    acc_d  = acc_q;
    hold_d = hold_q;
    if (dump_enable) begin
      hold_d = acc_q;
      acc_d  = sample_enable ? product_i : '0;
    end else if (sample_enable) begin
      acc_d = acc_q + product_i;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      hold_q <= '0;
    end else begin
      acc_q  <= acc_d;
      hold_q <= hold_d;
    end
  end

  assign hold_o = hold_q;

endmodule

// File: rtl/namuru_accumulator.sv
// Tracking-channel correlator back end: six E/P/L x I/Q accumulators, sample counter
// and dump handshake. Optional saturation: NAMURU_ACCUM_SAT_EN.
module namuru_accumulator #(
  parameter int SAMPLE_W = namuru_pkg::SAMPLE_W,
  parameter int ACC_W    = namuru_pkg::ACC_W,
  parameter int CNT_W    = namuru_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sample_enable,
  input  logic signed [SAMPLE_W-1:0] i_baseband,
  input  logic signed [SAMPLE_W-1:0] q_baseband,
  input  logic                       early,
  input  logic                       prompt,
  input  logic                       late,
  input  logic                       dump_enable,
  input  logic                       accum_read,
  output logic signed [ACC_W-1:0]    i_early,
  output logic signed [ACC_W-1:0]    q_early,
  output logic signed [ACC_W-1:0]    i_prompt,
  output logic signed [ACC_W-1:0]    q_prompt,
  output logic signed [ACC_W-1:0]    i_late,
  output logic signed [ACC_W-1:0]    q_late,
  output logic [CNT_W-1:0]           sample_count,
  output logic                       accum_valid,
  output logic                       accum_overwrite
);
  import namuru_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Channel order: I/Q early, I/Q prompt, I/Q late.
  logic signed [ACC_W-1:0] product [6];
  logic signed [ACC_W-1:0] hold    [6];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_hold_q, cnt_hold_d;
  logic             valid_q, valid_d;
  logic             ovw_q, ovw_d;

  always_comb begin
    product[0] = chip_product(early,  i_baseband);
    product[1] = chip_product(early,  q_baseband);
    product[2] = chip_product(prompt, i_baseband);
    product[3] = chip_product(prompt, q_baseband);
    product[4] = chip_product(late,   i_baseband);
    product[5] = chip_product(late,   q_baseband);
  end

  for (genvar g = 0; g < 6; g++) begin : g_ch
    namuru_accum_ch #(.ACC_W(ACC_W)) u_ch (
      .clk          (clk),
      .rstn         (rstn),
      .sample_enable(sample_enable),
      .dump_enable  (dump_enable),
      .product_i    (product[g]),
      .hold_o       (hold[g])
    );
  end

  always_comb begin
    cnt_d      = cnt_q;
    cnt_hold_d = cnt_hold_q;
    if (dump_enable) begin
      cnt_hold_d = cnt_q;
      cnt_d      = sample_enable ? CNT_W'(1) : '0;
    end else if (sample_enable && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A dump beats a same-cycle read for valid; a read always clears overwrite.
  always_comb begin
    valid_d = valid_q;
    ovw_d   = ovw_q;
    if (dump_enable)     valid_d = 1'b1;
    else if (accum_read) valid_d = 1'b0;
    if (accum_read)                  ovw_d = 1'b0;
    else if (dump_enable && valid_q) ovw_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      cnt_hold_q <= '0;
      valid_q    <= 1'b0;
      ovw_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cnt_hold_q <= cnt_hold_d;
      valid_q    <= valid_d;
      ovw_q      <= ovw_d;
    end
  end

  assign i_early         = hold[0];
  assign q_early         = hold[1];
  assign i_prompt        = hold[2];
  assign q_prompt        = hold[3];
  assign i_late          = hold[4];
  assign q_late          = hold[5];
  assign sample_count    = cnt_hold_q;
  assign accum_valid     = valid_q;
  assign accum_overwrite = ovw_q;

endmodule
